ps2_frame_rx: RTL and testbench
===============================

# ps2_frame_rx

Upstream PS/2 device-to-host receiver that sits between the raw keyboard pins and the calculator's scancode state machine. It synchronises and deglitches `ps2_clk` and deserialises 11-bit frames: start, 8 data bits LSB-first, odd parity, stop. It validates each frame and delivers one byte per frame as a single-cycle strobe, with a per-frame error indication and a mid-frame timeout.

## Interface
- `FILTER_LEN`, default 6: consecutive equal samples of synchronised `ps2_clk` required to change the filtered level (range 2–16).
- `TIMEOUT_CYCLES`, default 6000: maximum `clk` cycles between falling edges inside a frame.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw keyboard clock, asynchronous.
- `ps2_data`  in  1  raw keyboard data, asynchronous.
- `rx_data`  out  8  last delivered byte; held until the next delivery.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` and the flags are valid in that cycle.
- `rx_break`  out  1  delivered byte was preceded by F0 (only with the macro, else 0).
- `rx_ext`  out  1  delivered byte was preceded by E0 (only with the macro, else 0).
- `rx_err`  out  1  one-cycle strobe; the frame was discarded.
- `rx_err_code`  out  2  01 parity, 10 framing (stop=0), 11 timeout; held until the next `rx_err`.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- Clock: `reset` is asynchronous, active-high; the clock is `clk`.
- Reset values:
  - all outputs 0;
  - synchroniser flops and the filtered clock level 1 (bus idle);
  - FSM in IDLE, bit counter 0, timeout counter 0, pending flags cleared.
- `ps2_clk` and `ps2_data` each pass through 2 flops.
- Synchronised clock filter: the filtered level flips only after `FILTER_LEN` consecutive samples of the opposite value. A falling edge is the filtered 1→0 transition (one-cycle `fall` pulse).
- FSM runs on `fall` pulses only:
  - IDLE: data=0 → DATA, bit counter 0. Data=1 → stay in IDLE, no error.
  - DATA: shift data into bit[cnt]. After bit 7 → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP:
    - if data=1 and XOR(data bits, parity)=1: deliver the byte → IDLE;
    - else if the XOR is 0: `rx_err`, code 01 → IDLE;
    - else (stop=0): `rx_err`, code 10 → IDLE.
    - Parity is checked before the stop bit.
- Timeout counter:
  - resets on every `fall`; counts while the FSM is not in IDLE.
  - Reaching `TIMEOUT_CYCLES` gives `rx_err`, code 11, and the FSM returns to IDLE.
  - `fall` in the same cycle as expiry: the edge wins and the counter restarts.
- An error clears the pending break/ext flags and does not change `rx_data`.
- `reset` mid-frame aborts the frame immediately. No strobe is emitted.

## Timing
- `fall` occurs 2 + `FILTER_LEN` cycles after the raw falling edge (minimum).
- `rx_valid` / `rx_err` is registered and asserts 1 cycle after the stop-bit `fall`. It is high for exactly 1 cycle.
- `rx_valid` and `rx_err` are never high together.
- Back-to-back frames need no idle gap beyond the PS/2 protocol minimum. The next start bit can be accepted on the `fall` following delivery.
- `busy` rises the cycle after the start-bit `fall` and falls together with the strobe.

## Configuration
- `PS2_BREAK_DECODE_EN` defined:
  - a valid F0 byte sets `pending_break`; a valid E0 byte sets `pending_ext`. Neither produces `rx_valid`.
  - The next valid non-prefix byte is delivered with `rx_break`/`rx_ext` = the pending flags, which then clear.
- Undefined: every valid byte, including F0 and E0, is delivered raw, and `rx_break` = `rx_ext` = 0.

## Structure
- Package `ps2_pkg` holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - error-code constants `PS2_ERR_PARITY`, `PS2_ERR_FRAME`, `PS2_ERR_TIMEOUT`;
  - `PS2_BREAK` = 8'hF0 and `PS2_EXT` = 8'hE0.
- Sub-module `ps2_line_filter`: 2-flop synchroniser, `FILTER_LEN` filter and falling-edge pulse. It is instantiated for `ps2_clk`; `ps2_data` uses the synchroniser only.

## Test plan
- Frame 0x36 (parity 1, stop 1), 100 µs PS/2 period → one `rx_valid`, `rx_data`=0x36, `rx_err`=0.
- Frame 0x16 with parity forced to 1 → `rx_err`, code 01, no `rx_valid`, `rx_data` unchanged.
- Frame 0x55 with stop=0 → `rx_err`, code 10. A following good 0x55 frame → `rx_valid` with 0x55.
- Start bit plus 4 data bits, then the clock stops high → `rx_err` code 11 exactly `TIMEOUT_CYCLES` after the last `fall`. `busy` drops. The next frame is received correctly.
- With `PS2_BREAK_DECODE_EN`: E0, F0, 0x75 → single `rx_valid`, `rx_data`=0x75, `rx_break`=1, `rx_ext`=1. Without the macro: three strobes, E0, F0, 0x75.
- `ps2_clk` glitch low for `FILTER_LEN`-1 cycles in IDLE → no `fall`, `busy` stays 0. `reset` pulse after bit 3 of a frame → all outputs 0, no strobe, the next full frame is delivered.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [1:0] PS2_ERR_PARITY  = 2'b01;
    localparam logic [1:0] PS2_ERR_FRAME   = 2'b10;
    localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus a run-length deglitch filter; emits a one-cycle
// pulse on each filtered 1->0 transition of the line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] run_cnt;

    // The filtered level only moves after FILTER_LEN consecutive samples
    // disagreeing with it; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            sync_1 <= line;
            sync_2 <= sync_1;
            fall   <= 1'b0;
            if (sync_2 != level) begin
                if (run_cnt == CW'(FILTER_LEN - 1)) begin
                    level   <= sync_2;
                    run_cnt <= '0;
                    fall    <= level;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB-first, odd parity, stop.
// Define PS2_BREAK_DECODE_EN to fold F0/E0 prefixes into rx_break/rx_ext.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 6,
    parameter int TIMEOUT_CYCLES = 6000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_break,
    output logic       rx_ext,
    output logic       rx_err,
    output logic [1:0] rx_err_code,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall;
    logic          data_s1;
    logic          data_s2;
    ps2_state_e    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] tmo_cnt;
    logic          frame_odd;
`ifdef PS2_BREAK_DECODE_EN
    logic          pending_break;
    logic          pending_ext;
`endif

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .reset(reset),
        .line (ps2_clk),
        .fall (fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign frame_odd = (^shreg) ^ parity_bit;
    assign busy      = (state != IDLE);

    // rx_valid and rx_err are single-cycle strobes with no back-pressure:
    // the consumer must take rx_data / rx_err_code in the strobe cycle,
    // although both are held afterwards until the next strobe of their kind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            tmo_cnt     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_break    <= 1'b0;
            rx_ext      <= 1'b0;
            rx_err      <= 1'b0;
            rx_err_code <= '0;
`ifdef PS2_BREAK_DECODE_EN
            pending_break <= 1'b0;
            pending_ext   <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (fall) begin
                // An edge always restarts the gap timer, even on expiry.
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg[bit_cnt] <= data_s2;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        parity_bit <= data_s2;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_s2 && frame_odd) begin
`ifdef PS2_BREAK_DECODE_EN
                            if (shreg == PS2_BREAK) begin
                                pending_break <= 1'b1;
                            end else if (shreg == PS2_EXT) begin
                                pending_ext <= 1'b1;
                            end else begin
                                rx_valid      <= 1'b1;
                                rx_data       <= shreg;
                                rx_break      <= pending_break;
                                rx_ext        <= pending_ext;
                                pending_break <= 1'b0;
                                pending_ext   <= 1'b0;
                            end
`else
                            rx_valid <= 1'b1;
                            rx_data  <= shreg;
                            rx_break <= 1'b0;
                            rx_ext   <= 1'b0;
`endif
                        end else begin
                            rx_err      <= 1'b1;
                            rx_err_code <= frame_odd ? PS2_ERR_FRAME : PS2_ERR_PARITY;
`ifdef PS2_BREAK_DECODE_EN
                            pending_break <= 1'b0;
                            pending_ext   <= 1'b0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state       <= IDLE;
                    tmo_cnt     <= '0;
                    rx_err      <= 1'b1;
                    rx_err_code <= PS2_ERR_TIMEOUT;
`ifdef PS2_BREAK_DECODE_EN
                    pending_break <= 1'b0;
                    pending_ext   <= 1'b0;
`endif
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: frames, error codes, timeout, prefixes,
// glitch rejection and mid-frame reset.
module tb_ps2_frame_rx;

    localparam int FL  = 4;
    localparam int TMO = 200;
    localparam int HP  = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_break;
    logic       rx_ext;
    logic       rx_err;
    logic [1:0] rx_err_code;
    logic       busy;

    int n_cmp;
    int n_fail;
    int both_cnt;

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic [1:0] err_q[$];

    ps2_frame_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_break   (rx_break),
        .rx_ext     (rx_ext),
        .rx_err     (rx_err),
        .rx_err_code(rx_err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) got_q.push_back({rx_break, rx_ext, rx_data});
            if (rx_err) err_q.push_back(rx_err_code);
            if (rx_valid && rx_err) both_cnt++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HP);
        ps2_clk = 1'b0;
        wait_cyc(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        ps2_data = 1'b1;
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
        err_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(3);
        n_cmp++;
        if ({rx_valid, rx_err, rx_break, rx_ext, busy, rx_err_code, rx_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rx_valid, rx_err, rx_break, rx_ext, busy, rx_err_code, rx_data});
        end
        reset = 1'b0;
        wait_cyc(20);
        n_cmp++;
        if ({rx_valid, rx_err, busy, rx_data} !== 11'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h want 0", {rx_valid, rx_err, busy, rx_data});
        end
    endtask

    task automatic test_good_frame();
        clear_queues();
        send_frame(8'h36, odd_par(8'h36), 1'b1);
        wait_cyc(5);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h36}) begin
            n_fail++;
            $display("FAIL good_36: got n=%0d v=%h want n=1 v=036", got_q.size(), got_q[0]);
        end
        n_cmp++;
        if (err_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_36_err: got %0d errs want 0", err_q.size());
        end
        n_cmp++;
        if (busy !== 1'b0 || rx_data !== 8'h36) begin
            n_fail++;
            $display("FAIL good_36_hold: got busy=%b data=%h want 0/36", busy, rx_data);
        end
    endtask

    task automatic test_parity_error();
        clear_queues();
        send_frame(8'h16, 1'b1, 1'b1);
        wait_cyc(5);
        n_cmp++;
        if (err_q.size() != 1 || err_q[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL parity_err: got n=%0d code=%b want n=1 code=01", err_q.size(), err_q[0]);
        end
        n_cmp++;
        if (got_q.size() != 0 || rx_data !== 8'h36 || rx_err_code !== 2'b01) begin
            n_fail++;
            $display("FAIL parity_side: got n=%0d data=%h code=%b want 0/36/01",
                     got_q.size(), rx_data, rx_err_code);
        end
    endtask

    task automatic test_framing_error();
        clear_queues();
        send_frame(8'h55, odd_par(8'h55), 1'b0);
        wait_cyc(5);
        n_cmp++;
        if (err_q.size() != 1 || err_q[0] !== 2'b10 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_err: got n=%0d code=%b valid=%0d want 1/10/0",
                     err_q.size(), err_q[0], got_q.size());
        end
        send_frame(8'h55, odd_par(8'h55), 1'b1);
        wait_cyc(5);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h55} || rx_err_code !== 2'b10) begin
            n_fail++;
            $display("FAIL frame_recover: got n=%0d v=%h code=%b want 1/055/10",
                     got_q.size(), got_q[0], rx_err_code);
        end
    endtask

    // Raw fall of data bit 3 is driven 1 after posedge 0. The synchroniser and
    // filter produce the fall pulse after posedge 2+FL, it is consumed at
    // posedge 3+FL, and the timer then expires TMO cycles later.
    task automatic test_timeout();
        int err_k;
        logic busy_before;
        logic [7:0] d;
        d = 8'h0B;
        err_k = 0;
        busy_before = 1'b0;
        clear_queues();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        ps2_data = d[3];
        wait_cyc(HP);
        ps2_clk = 1'b0;
        for (int k = 1; k <= TMO + 100; k++) begin
            @(posedge clk);
            #1;
            if (rx_err && err_k == 0) err_k = k;
            if (k == 2 + FL + TMO) busy_before = busy;
            if (k == HP) ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        n_cmp++;
        if (err_k != 3 + FL + TMO) begin
            n_fail++;
            $display("FAIL timeout_cycle: got %0d want %0d", err_k, 3 + FL + TMO);
        end
        n_cmp++;
        if (err_q.size() != 1 || err_q[0] !== 2'b11 || busy_before !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_code: got n=%0d code=%b busy_pre=%b busy=%b want 1/11/1/0",
                     err_q.size(), err_q[0], busy_before, busy);
        end
        send_frame(8'h5A, odd_par(8'h5A), 1'b1);
        wait_cyc(5);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h5A}) begin
            n_fail++;
            $display("FAIL timeout_recover: got n=%0d v=%h want 1/05a", got_q.size(), got_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        send_frame(8'h12, odd_par(8'h12), 1'b1);
        send_frame(8'h34, odd_par(8'h34), 1'b1);
        wait_cyc(5);
        exp_q.push_back({2'b00, 8'h12});
        exp_q.push_back({2'b00, 8'h34});
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_prefix();
        clear_queues();
        send_frame(8'hE0, odd_par(8'hE0), 1'b1);
        send_frame(8'hF0, odd_par(8'hF0), 1'b1);
        send_frame(8'h75, odd_par(8'h75), 1'b1);
        wait_cyc(5);
`ifdef PS2_BREAK_DECODE_EN
        exp_q.push_back({2'b11, 8'h75});
`else
        exp_q.push_back({2'b00, 8'hE0});
        exp_q.push_back({2'b00, 8'hF0});
        exp_q.push_back({2'b00, 8'h75});
`endif
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL prefix_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL prefix_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    // Data is held low during the glitch so that a leaked fall would start a frame.
    task automatic test_glitch();
        logic busy_seen;
        busy_seen = 1'b0;
        clear_queues();
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(FL - 1);
        ps2_clk = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wait_cyc(1);
            busy_seen = busy_seen | busy;
        end
        ps2_data = 1'b1;
        wait_cyc(TMO + 50);
        n_cmp++;
        if (busy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: got %b want 0", busy_seen);
        end
        n_cmp++;
        if (err_q.size() != 0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_strobe: got errs=%0d valids=%0d want 0/0", err_q.size(), got_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h29;
        clear_queues();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        reset = 1'b1;
        wait_cyc(2);
        n_cmp++;
        if ({rx_valid, rx_err, rx_break, rx_ext, busy, rx_err_code, rx_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h want 0",
                     {rx_valid, rx_err, rx_break, rx_ext, busy, rx_err_code, rx_data});
        end
        reset = 1'b0;
        wait_cyc(TMO + 50);
        n_cmp++;
        if (err_q.size() != 0 || got_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got errs=%0d valids=%0d busy=%b want 0/0/0",
                     err_q.size(), got_q.size(), busy);
        end
        send_frame(d, odd_par(d), 1'b1);
        wait_cyc(5);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h29}) begin
            n_fail++;
            $display("FAIL midreset_next: got n=%0d v=%h want 1/029", got_q.size(), got_q[0]);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        both_cnt = 0;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing_error();
        test_timeout();
        test_back_to_back();
        test_prefix();
        test_glitch();
        test_reset_midframe();
        n_cmp++;
        if (both_cnt != 0) begin
            n_fail++;
            $display("FAIL valid_err_overlap: got %0d cycles want 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
